// File: rtl/lz_pkg.sv
// Shared definitions for the LZ77 encoder job scheduler and downstream token decode.
package lz_pkg;

  localparam int ENC_BUF_DEPTH = 30;
  localparam int MAX_LEN       = ENC_BUF_DEPTH - 1;  // one buffer entry holds the sentinel
  localparam int WD_CYCLES     = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENC_RST,
    ST_LOAD,
    ST_WAIT_TOK,
    ST_DONE
  } lz_state_e;

  typedef struct packed {
    logic       src;
    logic [3:0] offset;
    logic [3:0] match_len;
    logic [7:0] chr;
  } lz_tok_t;

  function automatic logic len_legal(input logic [4:0] len, input int max_len);
    return (len != 5'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/lz_rr_arb.sv
// Two-way round-robin arbiter; a tie goes to the source that was not served last.
module lz_rr_arb (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) last_q <= 1'b1;
    else           last_q <= last_d;
  end

  always_comb begin
    last_d      = upd_i ? upd_id_i : last_q;
    gnt_valid_o = |req_i;
    gnt_id_o    = 1'b0;
    case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ~last_q;
      default: gnt_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/lz_enc_sched.sv
// Shares one LZ77 encoder between two character sources: arbitrate, reset encoder,
// load the job, forward tagged tokens, and end the job on last token or watchdog.
module lz_enc_sched
  import lz_pkg::*;
#(
  parameter int MAX_LEN   = lz_pkg::MAX_LEN,
  parameter int WD_CYCLES = lz_pkg::WD_CYCLES
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [1:0] req_i,
  input  logic [4:0] req_len0_i,
  input  logic [4:0] req_len1_i,
  input  logic [7:0] src_char0_i,
  input  logic [7:0] src_char1_i,
  output logic [1:0] src_pop_o,
  output logic [1:0] gnt_o,
  output logic       enc_rst_o,
  output logic       enc_code_valid_o,
  output logic [7:0] enc_chardata_o,
  input  logic       enc_valid_i,
  input  logic       enc_encode_i,
  input  logic [3:0] enc_offset_i,
  input  logic [3:0] enc_match_len_i,
  input  logic [7:0] enc_char_nxt_i,
  output logic       tok_valid_o,
  output logic       tok_src_o,
  output logic [3:0] tok_offset_o,
  output logic [3:0] tok_match_len_o,
  output logic [7:0] tok_char_o,
  output logic       tok_last_o,
  output logic [1:0] job_done_o,
  output logic [1:0] job_err_o,
  output logic       busy_o
);

  lz_state_e  state_q, state_d;
  logic       g_q, g_d;
  logic [4:0] len_q, len_d;
  logic [1:0] gnt_q, gnt_d;
  logic [4:0] char_cnt_q, char_cnt_d;
  logic [5:0] consumed_q, consumed_d;
  logic [7:0] wd_q, wd_d;
  lz_tok_t    tok_q, tok_d;
  logic       tok_valid_q, tok_valid_d;
  logic       tok_last_q, tok_last_d;
  logic [1:0] job_done_q, job_done_d;
  logic [1:0] job_err_q, job_err_d;

  logic       arb_valid, arb_id, arb_upd;
  logic [1:0] g_oh;
  logic [5:0] consumed_sum;
  logic [7:0] wd_inc;

  lz_rr_arb u_arb (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .req_i       (req_i),
    .upd_i       (arb_upd),
    .upd_id_i    (g_q),
    .gnt_valid_o (arb_valid),
    .gnt_id_o    (arb_id)
  );

  assign g_oh         = g_q ? 2'b10 : 2'b01;
  assign consumed_sum = consumed_q + {2'b00, enc_match_len_i} + 6'd1;
  assign wd_inc       = wd_q + 8'd1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      g_q         <= 1'b0;
      len_q       <= '0;
      gnt_q       <= '0;
      char_cnt_q  <= '0;
      consumed_q  <= '0;
      wd_q        <= '0;
      tok_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_last_q  <= 1'b0;
      job_done_q  <= '0;
      job_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      len_q       <= len_d;
      gnt_q       <= gnt_d;
      char_cnt_q  <= char_cnt_d;
      consumed_q  <= consumed_d;
      wd_q        <= wd_d;
      tok_q       <= tok_d;
      tok_valid_q <= tok_valid_d;
      tok_last_q  <= tok_last_d;
      job_done_q  <= job_done_d;
      job_err_q   <= job_err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    g_d              = g_q;
    len_d            = len_q;
    gnt_d            = gnt_q;
    char_cnt_d       = char_cnt_q;
    consumed_d       = consumed_q;
    wd_d             = wd_q;
    tok_d            = tok_q;
    tok_valid_d      = 1'b0;
    tok_last_d       = 1'b0;
    job_done_d       = '0;
    job_err_d        = '0;
    arb_upd          = 1'b0;
    enc_rst_o        = 1'b0;
    enc_code_valid_o = 1'b0;
    enc_chardata_o   = '0;
    src_pop_o        = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          g_d     = arb_id;
          len_d   = arb_id ? req_len1_i : req_len0_i;
          gnt_d   = arb_id ? 2'b10 : 2'b01;
          state_d = len_legal(len_d, MAX_LEN) ? ST_ENC_RST : ST_DONE;
        end
      end
      ST_ENC_RST: begin
        enc_rst_o  = 1'b1;
        char_cnt_d = '0;
        consumed_d = '0;
        wd_d       = '0;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        enc_code_valid_o = 1'b1;
        enc_chardata_o   = g_q ? src_char1_i : src_char0_i;
        src_pop_o        = g_oh;
        char_cnt_d       = char_cnt_q + 5'd1;
        if (char_cnt_q == len_q - 5'd1) state_d = ST_WAIT_TOK;
      end
      ST_WAIT_TOK: begin
        if (enc_valid_i && enc_encode_i) begin
          tok_d       = '{src: g_q, offset: enc_offset_i,
                          match_len: enc_match_len_i, chr: enc_char_nxt_i};
          tok_valid_d = 1'b1;
          consumed_d  = consumed_sum;
          wd_d        = '0;
          if (consumed_sum >= {1'b0, len_q}) begin
            tok_last_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else begin
          wd_d = wd_inc;
          if (wd_inc == 8'(WD_CYCLES)) begin
            job_err_d = g_oh;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Illegal-length jobs report their error alongside job_done.
        job_done_d = g_oh;
        if (!len_legal(len_q, MAX_LEN)) job_err_d = g_oh;
        gnt_d   = '0;
        arb_upd = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt_o           = gnt_q;
  assign tok_valid_o     = tok_valid_q;
  assign tok_src_o       = tok_q.src;
  assign tok_offset_o    = tok_q.offset;
  assign tok_match_len_o = tok_q.match_len;
  assign tok_char_o      = tok_q.chr;
  assign tok_last_o      = tok_last_q;
  assign job_done_o      = job_done_q;
  assign job_err_o       = job_err_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule
